mon_dff_pack: RTL

Downstream monitor stage for the DFF under test. It samples the DFF output (dout) on every enabled clock and packs the bits LSB-first into WORD_W-bit words. Completed or flushed words go into a small FIFO. The s2cif transfer stage drains the FIFO through a valid/ready handshake and forwards each word to the C-side checker.

---
 rtl/mon_dff_pack.sv | 113 +++++++++++
 1 files changed

// File: rtl/mon_dff_pack.sv
// Monitor stage: samples the DFF output on enabled clocks, packs the bits
// LSB-first into words, and queues completed or flushed words in a small
// first-word-fall-through FIFO drained through a valid/ready handshake.
module mon_dff_pack #(
    parameter int unsigned id     = 0,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       dout,
    input  logic                       flush,
    output logic [WORD_W-1:0]          word_data,
    output logic [$clog2(WORD_W):0]    word_cnt,
    output logic [7:0]                 word_id,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int unsigned CW = $clog2(WORD_W) + 1;
    localparam int unsigned IW = $clog2(WORD_W);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(WORD_W);
    localparam logic [LW-1:0] MAX_LEVEL = LW'(DEPTH);

    typedef enum logic {
        ST_EMPTY,
        ST_FILL
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   pack;
    logic [WORD_W-1:0]   pack_nxt;
    logic [CW-1:0]       bit_cnt;
    logic [CW-1:0]       cnt_nxt;
    logic                push;
    logic                pop;
    logic                accept;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [WORD_W-1:0]   mem_data [DEPTH];
    logic [CW-1:0]       mem_cnt  [DEPTH];

    // Merge this edge's sample first, so a flush on the same edge includes it
    always_comb begin
        pack_nxt = pack;
        if (en) begin
            pack_nxt[bit_cnt[IW-1:0]] = dout;
        end
        cnt_nxt = bit_cnt + CW'(en);
        push    = (cnt_nxt == FULL_CNT) || (flush && ((state == ST_FILL) || en));
    end

    assign pop    = word_valid && word_ready;
    // A pop on the same edge frees the slot a full FIFO would otherwise lack
    assign accept = push && ((level != MAX_LEVEL) || pop);

    // Pack FSM: collect bits, clear on every emitted (or dropped) word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_EMPTY;
            pack    <= '0;
            bit_cnt <= '0;
        end else if (push) begin
            state   <= ST_EMPTY;
            pack    <= '0;
            bit_cnt <= '0;
        end else if (en) begin
            state   <= ST_FILL;
            pack    <= pack_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (push && !accept) begin
                overflow <= 1'b1;
            end
            level <= level + LW'(accept) - LW'(pop);
        end
    end

    // FIFO storage; contents are only observed through the valid-gated head
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_data[wr_ptr] <= pack_nxt;
            mem_cnt[wr_ptr]  <= cnt_nxt;
        end
    end

    assign word_valid = (level != '0);
    assign word_data  = word_valid ? mem_data[rd_ptr] : '0;
    assign word_cnt   = word_valid ? mem_cnt[rd_ptr]  : '0;
    assign word_id    = 8'(id);

endmodule
